// File: rtl/bp_dma_responder_pkg.sv
// Shared types and sizing helpers for the DMA responder.
// The DMA packet declaration macro is provided here when no external
// bsg_cache package has already defined it.

`ifndef DECLARE_BSG_CACHE_DMA_PKT_S
`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp, mask_width_mp) \
    typedef struct packed { \
        logic                     write_not_read; \
        logic [addr_width_mp-1:0] addr; \
        logic [mask_width_mp-1:0] mask; \
    } bsg_cache_dma_pkt_s
`endif

package bp_dma_responder_pkg;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_wait  = 2'd1,
        e_read  = 2'd2,
        e_write = 2'd3
    } bp_dma_resp_state_e;

    // Fill beats per cache block.
    function automatic int beats_f(input int words, input int word_w, input int fill_w);
        return words * word_w / fill_w;
    endfunction

    // Cache words carried by one fill beat.
    function automatic int words_per_beat_f(input int fill_w, input int word_w);
        return fill_w / word_w;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int cnt_width_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_dma_responder_mem.sv
// Flop-array backing store: one combinational read port, one write port
// with a per-word write mask. Contents are deliberately not reset.

module bp_dma_responder_mem
    import bp_dma_responder_pkg::*;
#(
    parameter  int els_p        = 1024,
    parameter  int width_p      = 64,
    parameter  int word_width_p = 64,
    localparam int addr_w_lp    = cnt_width_f(els_p),
    localparam int words_lp     = words_per_beat_f(width_p, word_width_p)
) (
    input  logic                 clk_i,
    input  logic [addr_w_lp-1:0] rd_addr_i,
    output logic [width_p-1:0]   rd_data_o,
    input  logic                 wr_v_i,
    input  logic [addr_w_lp-1:0] wr_addr_i,
    input  logic [width_p-1:0]   wr_data_i,
    input  logic [words_lp-1:0]  wr_mask_i
);

    logic [width_p-1:0] r_mem [els_p];

    assign rd_data_o = r_mem[rd_addr_i];

    // Word-granular write; masked-off words hold their previous value.
    always_ff @(posedge clk_i) begin
        if (wr_v_i) begin
            for (int w = 0; w < words_lp; w++) begin
                if (wr_mask_i[w])
                    r_mem[wr_addr_i][w*word_width_p +: word_width_p] <= wr_data_i[w*word_width_p +: word_width_p];
            end
        end
    end

endmodule

// File: rtl/bp_dma_responder.sv
// Memory-side DMA responder: streams a block of fill beats out for reads,
// absorbs a masked block of fill beats for writes.
// Optional feature macro: BP_DMA_RESP_LATENCY_EN adds a fixed read
// first-beat delay of latency_p cycles through a WAIT state.

module bp_dma_responder
    import bp_dma_responder_pkg::*;
#(
    parameter  int daddr_width_p         = 28,
    parameter  int block_size_in_words_p = 8,
    parameter  int word_width_p          = 64,
    parameter  int fill_width_p          = 64,
    parameter  int mem_els_p             = 1024,
    parameter  int latency_p             = 4,
    localparam int dma_pkt_width_lp      = 1 + daddr_width_p + block_size_in_words_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_ready_and_o,
    output logic [fill_width_p-1:0]     dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,
    input  logic [fill_width_p-1:0]     dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_ready_and_o,
    output logic                        busy_o
);

    `DECLARE_BSG_CACHE_DMA_PKT_S(daddr_width_p, block_size_in_words_p);

    localparam int beats_lp = beats_f(block_size_in_words_p, word_width_p, fill_width_p);
    localparam int wpb_lp   = words_per_beat_f(fill_width_p, word_width_p);
    localparam int cnt_w_lp = cnt_width_f(beats_lp);
    localparam int idx_w_lp = cnt_width_f(mem_els_p);
    localparam int off_lp   = $clog2(fill_width_p / 8);

    bsg_cache_dma_pkt_s   w_pkt;
    bp_dma_resp_state_e   r_state, w_state_next, w_read_start;
    logic [idx_w_lp-1:0]  r_base, w_base, w_mem_addr;
    logic [block_size_in_words_p-1:0] r_mask;
    logic [cnt_w_lp-1:0]  r_cnt;
    logic [wpb_lp-1:0]    w_beat_mask;
    logic                 w_last, w_mem_we;

    assign w_pkt = dma_pkt_i;

    // Beat index of the packet, block-aligned; upper address bits fall away.
    assign w_base      = idx_w_lp'(w_pkt.addr >> off_lp) & ~idx_w_lp'(beats_lp - 1);
    assign w_mem_addr  = r_base + idx_w_lp'(r_cnt);
    assign w_beat_mask = wpb_lp'(r_mask >> (r_cnt * wpb_lp));
    assign w_last      = (r_cnt == cnt_w_lp'(beats_lp - 1));
    assign busy_o      = (r_state != e_idle);

`ifdef BP_DMA_RESP_LATENCY_EN
    localparam int wait_w_lp = cnt_width_f(latency_p);
    logic [wait_w_lp-1:0] r_wait_cnt;

    // With latency_p <= 1 the first beat cannot come any sooner than READ allows.
    assign w_read_start = (latency_p > 1) ? e_wait : e_read;

    // Read-latency down-counter; WAIT exits as it steps from 1 to 0 so the
    // first beat lands exactly latency_p cycles after acceptance.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            r_wait_cnt <= '0;
        else if (r_state == e_idle)
            r_wait_cnt <= wait_w_lp'(latency_p - 1);
        else if (r_state == e_wait && r_wait_cnt != '0)
            r_wait_cnt <= r_wait_cnt - wait_w_lp'(1);
    end
`else
    localparam int unused_latency_lp = latency_p;
    assign w_read_start = e_read;
`endif

    // Next-state and handshake outputs; all outputs default low.
    always_comb begin
        w_state_next         = r_state;
        dma_pkt_ready_and_o  = 1'b0;
        dma_data_v_o         = 1'b0;
        dma_data_ready_and_o = 1'b0;
        w_mem_we             = 1'b0;
        case (r_state)
            e_idle: begin
                dma_pkt_ready_and_o = 1'b1;
                if (dma_pkt_v_i)
                    w_state_next = w_pkt.write_not_read ? e_write : w_read_start;
            end
`ifdef BP_DMA_RESP_LATENCY_EN
            e_wait: begin
                if (r_wait_cnt <= wait_w_lp'(1))
                    w_state_next = e_read;
            end
`endif
            e_read: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_and_i && w_last)
                    w_state_next = e_idle;
            end
            e_write: begin
                dma_data_ready_and_o = 1'b1;
                w_mem_we             = dma_data_v_i;
                if (dma_data_v_i && w_last)
                    w_state_next = e_idle;
            end
            default: w_state_next = e_idle;
        endcase
    end

    // State register plus packet capture and beat counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
            r_base  <= '0;
            r_mask  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == e_idle && dma_pkt_v_i) begin
                r_base <= w_base;
                r_mask <= w_pkt.mask;
                r_cnt  <= '0;
            end else if ((r_state == e_read && dma_data_ready_and_i) ||
                         (r_state == e_write && dma_data_v_i)) begin
                r_cnt <= r_cnt + cnt_w_lp'(1);
            end
        end
    end

    bp_dma_responder_mem #(
        .els_p        (mem_els_p),
        .width_p      (fill_width_p),
        .word_width_p (word_width_p)
    ) u_mem (
        .clk_i     (clk_i),
        .rd_addr_i (w_mem_addr),
        .rd_data_o (dma_data_o),
        .wr_v_i    (w_mem_we),
        .wr_addr_i (w_mem_addr),
        .wr_data_i (dma_data_i),
        .wr_mask_i (w_beat_mask)
    );

endmodule

// File: tb/tb_bp_dma_responder.sv
// Self-checking bench for bp_dma_responder (default parameters, 8 beats/block).
// Define BP_DMA_RESP_LATENCY_EN for both bench and RTL to cover the WAIT path.

module tb_bp_dma_responder;

`ifdef BP_DMA_RESP_LATENCY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 1;
`endif
    localparam int BEATS = 8;
    localparam int ELS   = 1024;

    logic        clk, rst_n;
    logic [36:0] pkt;
    logic        pkt_v, pkt_rdy;
    logic [63:0] dout, din;
    logic        dv_o, drdy_i, dv_i, drdy_o, busy;

    int errs   = 0;
    int checks = 0;

    logic [63:0] mdl [ELS];

    bp_dma_responder dut (
        .clk_i                (clk),
        .reset_n_i            (rst_n),
        .dma_pkt_i            (pkt),
        .dma_pkt_v_i          (pkt_v),
        .dma_pkt_ready_and_o  (pkt_rdy),
        .dma_data_o           (dout),
        .dma_data_v_o         (dv_o),
        .dma_data_ready_and_i (drdy_i),
        .dma_data_i           (din),
        .dma_data_v_i         (dv_i),
        .dma_data_ready_and_o (drdy_o),
        .busy_o               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block-aligned beat index of a byte address, wrapped to the memory depth.
    function automatic int blk_base(input logic [27:0] a);
        longint v;
        v = longint'(a);
        return int'(((v / 8) / BEATS * BEATS) % ELS);
    endfunction

    // Entered and left at a negedge. Junk write data is presented alongside the
    // packet and must not be consumed before the burst starts.
    task automatic do_write(input logic [27:0] addr, input logic [7:0] mask,
                            input logic [63:0] d [BEATS], input bit gaps, input string nm);
        int beat, cyc, base;
        base = blk_base(addr);
        pkt_v = 1'b1; pkt = {1'b1, addr, mask};
        dv_i = 1'b1; din = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        checks++; if (pkt_rdy !== 1'b1) begin errs++; $display("FAIL %s wr pkt_ready: got %b want 1", nm, pkt_rdy); end
        checks++; if (drdy_o !== 1'b0) begin errs++; $display("FAIL %s wr early data_ready: got %b want 0", nm, drdy_o); end
        @(negedge clk);
        pkt_v = 1'b0;
        beat = 0; cyc = 0;
        while (beat < BEATS && cyc < 200) begin
            dv_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            din  = d[beat];
            #1;
            checks++;
            if (drdy_o !== 1'b1 || pkt_rdy !== 1'b0 || dv_o !== 1'b0 || busy !== 1'b1) begin
                errs++;
                $display("FAIL %s wr beat%0d ctl: got rdy_o=%b pkt_rdy=%b v_o=%b busy=%b want 1 0 0 1",
                         nm, beat, drdy_o, pkt_rdy, dv_o, busy);
            end
            if (dv_i) beat++;
            @(negedge clk);
            cyc++;
        end
        dv_i = 1'b0;
        checks++; if (beat != BEATS) begin errs++; $display("FAIL %s wr timeout: got %0d beats want %0d", nm, beat, BEATS); end
        for (int b = 0; b < BEATS; b++)
            if (mask[b]) mdl[base + b] = d[b];
    endtask

    // mode 0: always ready, 1: ready toggles 1-0-1-0, 2: random ready.
    task automatic do_read(input logic [27:0] addr, input int mode, input string nm);
        int beat, cyc, first, last, vcnt, base;
        logic [63:0] prev;
        bit stall;
        base = blk_base(addr);
        pkt_v = 1'b1; pkt = {1'b0, addr, 8'h00}; drdy_i = 1'b0;
        #1;
        checks++; if (pkt_rdy !== 1'b1) begin errs++; $display("FAIL %s rd pkt_ready: got %b want 1", nm, pkt_rdy); end
        @(negedge clk);
        pkt_v = 1'b0;
        beat = 0; cyc = 1; first = -1; last = -1; vcnt = 0; stall = 0; prev = '0;
        while (beat < BEATS && cyc < 300) begin
            #1;
            checks++;
            if (pkt_rdy !== 1'b0 || busy !== 1'b1 || drdy_o !== 1'b0 || dv_o !== (cyc >= LAT)) begin
                errs++;
                $display("FAIL %s rd cyc%0d ctl: got pkt_rdy=%b busy=%b rdy_o=%b v=%b want 0 1 0 %b",
                         nm, cyc, pkt_rdy, busy, drdy_o, dv_o, (cyc >= LAT));
            end
            if (dv_o === 1'b1) begin
                if (first < 0) begin
                    first = cyc;
                    checks++; if (first != LAT) begin errs++; $display("FAIL %s rd first beat: got cyc %0d want %0d", nm, first, LAT); end
                end
                if (stall) begin
                    checks++; if (dout !== prev) begin errs++; $display("FAIL %s rd stall hold: got %h want %h", nm, dout, prev); end
                end
                case (mode)
                    0:       drdy_i = 1'b1;
                    1:       drdy_i = (vcnt % 2 == 0);
                    default: drdy_i = 1'($urandom_range(0, 1));
                endcase
                vcnt++;
                if (drdy_i) begin
                    checks++;
                    if (dout !== mdl[base + beat]) begin
                        errs++; $display("FAIL %s rd beat%0d data: got %h want %h", nm, beat, dout, mdl[base + beat]);
                    end
                    beat++;
                    last = cyc;
                end
                stall = !drdy_i;
                prev  = dout;
            end
            @(negedge clk);
            cyc++;
        end
        drdy_i = 1'b0;
        checks++; if (beat != BEATS) begin errs++; $display("FAIL %s rd timeout: got %0d beats want %0d", nm, beat, BEATS); end
        if (mode < 2) begin
            checks++;
            if (last != LAT + (mode == 1 ? 2*BEATS-2 : BEATS-1)) begin
                errs++; $display("FAIL %s rd last beat: got cyc %0d want %0d", nm, last, LAT + (mode == 1 ? 2*BEATS-2 : BEATS-1));
            end
        end
        #1;
        checks++;
        if (pkt_rdy !== 1'b1 || dv_o !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL %s rd end: got pkt_rdy=%b v=%b busy=%b want 1 0 0", nm, pkt_rdy, dv_o, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pkt_v = 1'b0; pkt = '0; drdy_i = 1'b0; dv_i = 1'b0; din = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (pkt_rdy !== 1'b1 || dv_o !== 1'b0 || drdy_o !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL reset: got pkt_rdy=%b v=%b rdy_o=%b busy=%b want 1 0 0 0", pkt_rdy, dv_o, drdy_o, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] d [BEATS];
        for (int i = 0; i < BEATS; i++) d[i] = 64'h1000 + 64'(i);
        do_write(28'h40, 8'hFF, d, 1'b0, "basic");
        do_read(28'h40, 0, "basic");
    endtask

    task automatic test_mask();
        logic [63:0] d [BEATS];
        for (int i = 0; i < BEATS; i++) d[i] = 64'hAAAA;
        do_write(28'h40, 8'h0F, d, 1'b0, "mask");
        do_read(28'h40, 0, "mask");
        checks++; if (mdl[blk_base(28'h40) + 5] !== 64'h1005) begin errs++; $display("FAIL mask model: got %h want %h", mdl[blk_base(28'h40) + 5], 64'h1005); end
    endtask

    task automatic test_backpressure();
        do_read(28'h40, 1, "toggle");
    endtask

    task automatic test_wrap();
        logic [63:0] d [BEATS];
        for (int i = 0; i < BEATS; i++) d[i] = 64'h5A5A_0000 + 64'(i);
        do_write(28'h40 + 28'(ELS * 8), 8'hFF, d, 1'b0, "wrap");
        do_read(28'h40, 0, "wrap");
    endtask

    task automatic test_reset_mid_read();
        int beat, cyc;
        pkt_v = 1'b1; pkt = {1'b0, 28'h40, 8'h00};
        @(negedge clk);
        pkt_v = 1'b0;
        beat = 0; cyc = 0;
        while (cyc < 100) begin
            #1;
            if (dv_o === 1'b1 && beat == 3) break;
            drdy_i = dv_o;
            if (dv_o === 1'b1) beat++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (beat != 3) begin errs++; $display("FAIL rstmid reach beat3: got %0d want 3", beat); end
        drdy_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pkt_rdy !== 1'b1 || dv_o !== 1'b0 || drdy_o !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL rstmid outputs: got pkt_rdy=%b v=%b rdy_o=%b busy=%b want 1 0 0 0", pkt_rdy, dv_o, drdy_o, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_read(28'h40, 0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [63:0] d [BEATS];
        logic [27:0] a;
        logic [7:0]  m;
        for (int it = 0; it < 4; it++) begin
            a = 28'($urandom);
            for (int i = 0; i < BEATS; i++) d[i] = {$urandom, $urandom};
            do_write(a, 8'hFF, d, 1'b1, "rnd_full");
            for (int i = 0; i < BEATS; i++) d[i] = {$urandom, $urandom};
            m = 8'($urandom);
            do_write(a, m, d, 1'b1, "rnd_part");
            do_read(a, 2, "rnd_read");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_backpressure();
        test_wrap();
        test_reset_mid_read();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
